reflet_wb_bridge: RTL and testbench

Downstream neighbour of the CPU address/memory unit. It converts that unit's RAM port into a single-master Wishbone classic bus: addr, data_out, write_en and data_in, all zero-wait-state and full-word.
- The bridge stalls the CPU by holding cpu_enable low while a bus cycle is outstanding.
- It keeps a one-word read buffer so the CPU sees stable data_in.
- Byte/sub-word masking stays upstream (read-modify-write), so every bus access is a full word.

---
 rtl/reflet_wb_bridge_pkg.sv | 17 +
 rtl/reflet_wb_timeout.sv | 43 ++++
 rtl/reflet_wb_bridge.sv | 185 ++++++++++++++++++
 tb/tb_reflet_wb_bridge.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_wb_bridge_pkg.sv
// Shared definitions for the reflet Wishbone bridge: bus-cycle state
// encodings and a helper that sizes the wait counter.
package reflet_wb_bridge_pkg;

  // Bridge states: IDLE serves the CPU from the buffer, READ/WRITE own the bus.
  typedef enum logic [1:0] {
    BRIDGE_IDLE  = 2'd0,
    BRIDGE_READ  = 2'd1,
    BRIDGE_WRITE = 2'd2
  } bridge_state_t;

  // Width needed to count 0..limit inclusive (never less than one bit).
  function automatic int unsigned wait_count_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/reflet_wb_timeout.sv
// Saturating bus-cycle wait counter. It counts cycles spent on the bus and
// flags expiry in the timeout-th waiting cycle, so a cycle that never gets
// an answer keeps cyc high for exactly timeout cycles. timeout=0 disables it.
module reflet_wb_timeout
  import reflet_wb_bridge_pkg::*;
#(
  parameter int unsigned timeout = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  generate
    if (timeout == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clear, run};
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = wait_count_width(timeout);
      localparam logic [CW-1:0] LIMIT = CW'(timeout);
      localparam logic [CW-1:0] LAST  = CW'(timeout - 1);

      logic [CW-1:0] count_reg;

      // Count waiting cycles; hold at the limit instead of wrapping.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (run && (count_reg != LIMIT)) begin
          count_reg <= count_reg + CW'(1);
        end
      end

      assign expired = run && (count_reg >= LAST);
    end
  endgenerate

endmodule

// File: rtl/reflet_wb_bridge.sv
// Converts the reflet address unit's RAM port into a single-master Wishbone
// classic bus. The CPU is stalled through cpu_enable while a bus cycle is
// outstanding and reads are served from a one-word buffer.
module reflet_wb_bridge
  import reflet_wb_bridge_pkg::*;
#(
  parameter int          wordsize = 16,
  parameter bit          refetch  = 1'b1,
  parameter int unsigned timeout  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_in,
  output logic                  cpu_enable,
  input  logic [wordsize-1:0]   cpu_addr,
  input  logic [wordsize-1:0]   cpu_data_out,
  input  logic                  cpu_write_en,
  output logic [wordsize-1:0]   cpu_data_in,
  output logic [wordsize-1:0]   wb_adr_o,
  output logic [wordsize-1:0]   wb_dat_o,
  input  logic [wordsize-1:0]   wb_dat_i,
  output logic                  wb_we_o,
  output logic [wordsize/8-1:0] wb_sel_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic                  bus_error
);

  bridge_state_t        state_reg, state_next;
  logic                 buf_valid_reg, buf_valid_next;
  logic [wordsize-1:0]  buf_addr_reg, buf_addr_next;
  logic [wordsize-1:0]  data_in_reg, data_in_next;
  logic                 write_done_reg, write_done_next;
  logic                 cyc_reg, cyc_next;
  logic                 we_reg, we_next;
  logic [wordsize-1:0]  adr_reg, adr_next;
  logic [wordsize-1:0]  dat_reg, dat_next;
  logic                 bus_error_reg, bus_error_next;

  logic hit;
  logic idle;
  logic expired;
  logic fault;

  assign idle  = (state_reg == BRIDGE_IDLE);
  assign hit   = buf_valid_reg && (buf_addr_reg == cpu_addr);
  assign fault = wb_err_i || expired;

  // The CPU only advances when its request is already satisfied.
  assign cpu_enable = enable_in && idle && (cpu_write_en ? write_done_reg : hit);

  // The counter restarts whenever the bridge is idle, so each bus cycle
  // begins with a fresh wait budget.
  reflet_wb_timeout #(
    .timeout(timeout)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle),
    .run    (!idle),
    .expired(expired)
  );

  // State and bus registers; reset drops cyc/stb immediately mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= BRIDGE_IDLE;
      buf_valid_reg  <= 1'b0;
      buf_addr_reg   <= '0;
      data_in_reg    <= '0;
      write_done_reg <= 1'b0;
      cyc_reg        <= 1'b0;
      we_reg         <= 1'b0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      bus_error_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      buf_valid_reg  <= buf_valid_next;
      buf_addr_reg   <= buf_addr_next;
      data_in_reg    <= data_in_next;
      write_done_reg <= write_done_next;
      cyc_reg        <= cyc_next;
      we_reg         <= we_next;
      adr_reg        <= adr_next;
      dat_reg        <= dat_next;
      bus_error_reg  <= bus_error_next;
    end
  end

  // Next-state logic: start cycles from IDLE, finish them on ack/err/timeout.
  always_comb begin
    state_next      = state_reg;
    buf_valid_next  = buf_valid_reg;
    buf_addr_next   = buf_addr_reg;
    data_in_next    = data_in_reg;
    write_done_next = write_done_reg;
    cyc_next        = cyc_reg;
    we_next         = we_reg;
    adr_next        = adr_reg;
    dat_next        = dat_reg;
    bus_error_next  = 1'b0;

    case (state_reg)
      BRIDGE_IDLE: begin
        if (cpu_enable) begin
          // The CPU consumes its request in this cycle.
          if (cpu_write_en) begin
            write_done_next = 1'b0;
          end else if (refetch) begin
            buf_valid_next = 1'b0;
          end
        end else if (enable_in) begin
          if (cpu_write_en && !write_done_reg) begin
            adr_next   = cpu_addr;
            dat_next   = cpu_data_out;
            we_next    = 1'b1;
            cyc_next   = 1'b1;
            state_next = BRIDGE_WRITE;
          end else if (!cpu_write_en && !hit) begin
            adr_next   = cpu_addr;
            we_next    = 1'b0;
            cyc_next   = 1'b1;
            state_next = BRIDGE_READ;
          end
        end
      end

      BRIDGE_READ: begin
        if (wb_ack_i) begin
          data_in_next   = wb_dat_i;
          buf_addr_next  = adr_reg;
          buf_valid_next = 1'b1;
          cyc_next       = 1'b0;
          state_next     = BRIDGE_IDLE;
        end else if (fault) begin
          // A failed read still completes so the CPU does not hang.
          data_in_next   = '1;
          buf_addr_next  = adr_reg;
          buf_valid_next = 1'b1;
          cyc_next       = 1'b0;
          bus_error_next = 1'b1;
          state_next     = BRIDGE_IDLE;
        end
      end

      BRIDGE_WRITE: begin
        if (wb_ack_i) begin
          // Write-through: the written word becomes the buffered word.
          write_done_next = 1'b1;
          buf_addr_next   = adr_reg;
          data_in_next    = dat_reg;
          buf_valid_next  = 1'b1;
          cyc_next        = 1'b0;
          we_next         = 1'b0;
          state_next      = BRIDGE_IDLE;
        end else if (fault) begin
          write_done_next = 1'b1;
          buf_valid_next  = 1'b0;
          cyc_next        = 1'b0;
          we_next         = 1'b0;
          bus_error_next  = 1'b1;
          state_next      = BRIDGE_IDLE;
        end
      end

      default: begin
        cyc_next   = 1'b0;
        state_next = BRIDGE_IDLE;
      end
    endcase
  end

  assign cpu_data_in = data_in_reg;
  assign wb_adr_o    = adr_reg;
  assign wb_dat_o    = dat_reg;
  assign wb_we_o     = we_reg;
  assign wb_cyc_o    = cyc_reg;
  assign wb_stb_o    = cyc_reg;
  assign wb_sel_o    = '1;
  assign bus_error   = bus_error_reg;

endmodule

// File: tb/tb_reflet_wb_bridge.sv
// Self-checking bench for reflet_wb_bridge. Instance A (refetch=0, timeout=4)
// is driven by a CPU task against a Wishbone slave model; instance B
// (refetch=1, timeout disabled) is exercised with a polling loop.
module tb_reflet_wb_bridge;

  localparam int W  = 16;
  localparam int TO = 4;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;
  localparam int M_BOTH = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic         enable_in = 1'b0;
  logic         cpu_enable;
  logic [W-1:0] cpu_addr = '0;
  logic [W-1:0] cpu_data_out = '0;
  logic         cpu_write_en = 1'b0;
  logic [W-1:0] cpu_data_in;
  logic [W-1:0] wb_adr_o, wb_dat_o;
  logic [W-1:0] wb_dat_i = '0;
  logic         wb_we_o, wb_cyc_o, wb_stb_o;
  logic [1:0]   wb_sel_o;
  logic         wb_ack_i = 1'b0;
  logic         wb_err_i = 1'b0;
  logic         bus_error;

  // Instance B signals
  logic         b_enable_in = 1'b0;
  logic         b_cpu_enable;
  logic [W-1:0] b_cpu_addr = '0;
  logic [W-1:0] b_cpu_data_in;
  logic [W-1:0] b_wb_adr_o, b_wb_dat_o;
  logic [W-1:0] b_wb_dat_i = '0;
  logic         b_wb_we_o, b_wb_cyc_o, b_wb_stb_o;
  logic [1:0]   b_wb_sel_o;
  logic         b_wb_ack_i = 1'b0;
  logic         b_bus_error;

  reflet_wb_bridge #(.wordsize(W), .refetch(1'b0), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .enable_in(enable_in), .cpu_enable(cpu_enable),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_write_en(cpu_write_en),
    .cpu_data_in(cpu_data_in), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .bus_error(bus_error)
  );

  reflet_wb_bridge #(.wordsize(W), .refetch(1'b1), .timeout(0)) dut_b (
    .clk(clk), .reset(reset), .enable_in(b_enable_in), .cpu_enable(b_cpu_enable),
    .cpu_addr(b_cpu_addr), .cpu_data_out(16'h0000), .cpu_write_en(1'b0),
    .cpu_data_in(b_cpu_data_in), .wb_adr_o(b_wb_adr_o), .wb_dat_o(b_wb_dat_o),
    .wb_dat_i(b_wb_dat_i), .wb_we_o(b_wb_we_o), .wb_sel_o(b_wb_sel_o),
    .wb_cyc_o(b_wb_cyc_o), .wb_stb_o(b_wb_stb_o), .wb_ack_i(b_wb_ack_i),
    .wb_err_i(1'b0), .bus_error(b_bus_error)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Slave memory (the device) and reference memory (what it should hold).
  logic [W-1:0] slv_mem [256];
  logic [W-1:0] ref_mem [256];
  int slv_mode = M_ACK;
  int slv_wait = 0;
  int slv_cnt = 0;

  // Reference model of the read buffer.
  bit           ref_valid = 1'b0;
  logic [W-1:0] ref_addr = '0;
  logic [W-1:0] ref_data = '0;

  // Wishbone slave for instance A: answers after slv_wait wait states.
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = W'($urandom);
    if (wb_cyc_o && wb_stb_o) begin
      if (slv_cnt >= slv_wait) begin
        case (slv_mode)
          M_ACK, M_BOTH: begin
            wb_ack_i = 1'b1;
            wb_err_i = (slv_mode == M_BOTH);
            if (wb_we_o) slv_mem[wb_adr_o[7:0]] = wb_dat_o;
            else         wb_dat_i = slv_mem[wb_adr_o[7:0]];
          end
          M_ERR:   wb_err_i = 1'b1;
          default: ;
        endcase
      end
      slv_cnt++;
    end else begin
      slv_cnt = 0;
    end
  end

  // Bus monitor for instance A: cycle starts, lengths, error pulses.
  logic         prev_cyc = 1'b0;
  int           n_bus = 0;
  int           n_err = 0;
  int           cyc_len = 0;
  logic [W-1:0] mon_adr = '0;
  logic [W-1:0] mon_dat = '0;
  logic         mon_we = 1'b0;
  logic [1:0]   mon_sel = '0;
  always @(posedge clk) begin
    #1;
    if (wb_cyc_o && !prev_cyc) begin
      n_bus++;
      cyc_len = 0;
      mon_adr = wb_adr_o;
      mon_dat = wb_dat_o;
      mon_we  = wb_we_o;
      mon_sel = wb_sel_o;
    end
    if (wb_cyc_o) cyc_len++;
    if (bus_error) n_err++;
    n_checks++;
    if (wb_stb_o !== wb_cyc_o) begin
      n_fail++;
      $display("FAIL stb_eq_cyc: stb=%b required cyc=%b", wb_stb_o, wb_cyc_o);
    end
    prev_cyc = wb_cyc_o;
  end

  // One CPU access on instance A, checked against the buffer/memory model.
  task automatic cpu_access(input logic we, input logic [W-1:0] a,
                            input logic [W-1:0] d, input int mode,
                            input int waits, input string tag);
    bit           miss;
    bit           ok;
    bit           exp_err;
    int           exp_len;
    int           exp_stall;
    int           stall;
    int           bus0;
    int           err0;
    logic [W-1:0] exp_data;
    miss      = we || !(ref_valid && ref_addr == a);
    ok        = (mode == M_ACK) || (mode == M_BOTH);
    exp_len   = (mode == M_NONE) ? TO : waits + 1;
    exp_stall = miss ? 1 + exp_len : 0;
    exp_err   = miss && !ok;
    if (!miss)   exp_data = ref_data;
    else if (ok) exp_data = we ? d : ref_mem[a[7:0]];
    else         exp_data = 16'hFFFF;

    @(negedge clk);
    slv_mode = mode;
    slv_wait = waits;
    enable_in = 1'b1;
    cpu_addr = a;
    cpu_data_out = d;
    cpu_write_en = we;
    bus0 = n_bus;
    err0 = n_err;
    stall = 0;
    #1;
    while (cpu_enable !== 1'b1 && stall < 60) begin
      @(negedge clk);
      #1;
      stall++;
    end
    $display("txn %s we=%0b adr=%h dat=%h mode=%0d waits=%0d stall=%0d data_in=%h",
             tag, we, a, d, mode, waits, stall, cpu_data_in);
    n_checks++;
    if (stall >= 60) begin
      n_fail++;
      $display("FAIL %s_enable_wait: cpu_enable never rose within %0d cycles", tag, stall);
      cpu_write_en = 1'b0;
      return;
    end
    n_checks++;
    if (stall !== exp_stall) begin
      n_fail++;
      $display("FAIL %s_stall: got %0d cycles required %0d", tag, stall, exp_stall);
    end
    n_checks++;
    if ((n_bus - bus0) !== int'(miss)) begin
      n_fail++;
      $display("FAIL %s_bus_cycles: got %0d required %0d", tag, n_bus - bus0, int'(miss));
    end
    n_checks++;
    if (bus_error !== exp_err || (n_err - err0) !== int'(exp_err)) begin
      n_fail++;
      $display("FAIL %s_bus_error: got pulse=%b count=%0d required %b", tag, bus_error,
               n_err - err0, exp_err);
    end
    if (!we) begin
      n_checks++;
      if (cpu_data_in !== exp_data) begin
        n_fail++;
        $display("FAIL %s_data_in: got %h required %h", tag, cpu_data_in, exp_data);
      end
    end
    if (miss) begin
      n_checks++;
      if (mon_adr !== a || mon_we !== we || mon_sel !== 2'b11 || cyc_len !== exp_len) begin
        n_fail++;
        $display("FAIL %s_bus_fields: adr=%h we=%b sel=%b len=%0d required %h %b 11 %0d",
                 tag, mon_adr, mon_we, mon_sel, cyc_len, a, we, exp_len);
      end
      if (we) begin
        n_checks++;
        if (mon_dat !== d) begin
          n_fail++;
          $display("FAIL %s_wb_dat: got %h required %h", tag, mon_dat, d);
        end
      end
    end
    // Model update
    if (we) begin
      if (ok) begin
        ref_mem[a[7:0]] = d;
        ref_valid = 1'b1; ref_addr = a; ref_data = d;
      end else begin
        ref_valid = 1'b0;
      end
    end else begin
      ref_valid = 1'b1; ref_addr = a; ref_data = exp_data;
    end
    // After the consuming edge: a write is granted for exactly one cycle,
    // a read stays available since the buffer is reused.
    @(posedge clk);
    #1;
    n_checks++;
    if (cpu_enable !== !we) begin
      n_fail++;
      $display("FAIL %s_enable_after: got %b required %b", tag, cpu_enable, !we);
    end
    cpu_write_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b required 000", wb_cyc_o, wb_stb_o, wb_we_o);
    end
    n_checks++;
    if (wb_adr_o !== '0 || wb_dat_o !== '0 || cpu_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_data: adr=%h dat=%h data_in=%h required 0", wb_adr_o, wb_dat_o, cpu_data_in);
    end
    n_checks++;
    if (wb_sel_o !== 2'b11 || bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sel_err: sel=%b err=%b required 11 0", wb_sel_o, bus_error);
    end
    n_checks++;
    if (cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_enable: got %b required 0", cpu_enable);
    end
    enable_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_read_ack();
    int bus0;
    cpu_access(1'b0, 16'h0010, 16'h0000, M_ACK, 0, "read_ack");
    bus0 = n_bus;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (n_bus !== bus0 || cpu_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL read_stable: new cycles=%0d enable=%b required 0 1", n_bus - bus0, cpu_enable);
    end
    cpu_access(1'b0, 16'h0010, 16'h0000, M_ACK, 0, "read_hit");
  endtask

  task automatic test_write_wait();
    cpu_access(1'b1, 16'h0020, 16'h1234, M_ACK, 3, "write_wait3");
    cpu_access(1'b0, 16'h0020, 16'h0000, M_ACK, 0, "read_after_write");
  endtask

  task automatic test_timeout();
    cpu_access(1'b0, 16'h0040, 16'h0000, M_NONE, 0, "read_timeout");
    cpu_access(1'b0, 16'h0040, 16'h0000, M_ACK, 0, "read_timeout_kept");
    cpu_access(1'b1, 16'h0041, 16'h7777, M_NONE, 0, "write_timeout");
  endtask

  task automatic test_err_ack();
    cpu_access(1'b1, 16'h0050, 16'hA5A5, M_ERR, 1, "write_err");
    cpu_access(1'b0, 16'h0050, 16'h0000, M_ACK, 0, "read_after_err");
    cpu_access(1'b0, 16'h0060, 16'h0000, M_BOTH, 2, "read_ack_and_err");
    cpu_access(1'b0, 16'h0061, 16'h0000, M_ERR, 0, "read_err");
  endtask

  task automatic test_addr_change();
    int bus0;
    int n;
    @(negedge clk);
    slv_mode = M_ACK;
    slv_wait = 3;
    enable_in = 1'b1;
    cpu_addr = 16'h0070;
    bus0 = n_bus;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 16'h0070) begin
      n_fail++;
      $display("FAIL addr_change_first: cyc=%b adr=%h required 1 0070", wb_cyc_o, wb_adr_o);
    end
    cpu_addr = 16'h0071;
    #1;
    n_checks++;
    if (wb_adr_o !== 16'h0070) begin
      n_fail++;
      $display("FAIL addr_change_held: adr=%h required 0070", wb_adr_o);
    end
    n = 0;
    while (cpu_enable !== 1'b1 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    $display("txn addr_change adr=0070->0071 cycles=%0d data_in=%h", n, cpu_data_in);
    n_checks++;
    if (n_bus - bus0 !== 2 || mon_adr !== 16'h0071 || cpu_data_in !== ref_mem[8'h71]) begin
      n_fail++;
      $display("FAIL addr_change_reread: cycles=%0d adr=%h data=%h required 2 0071 %h",
               n_bus - bus0, mon_adr, cpu_data_in, ref_mem[8'h71]);
    end
    ref_valid = 1'b1; ref_addr = 16'h0071; ref_data = ref_mem[8'h71];
  endtask

  task automatic test_enable_gate();
    int bus0;
    int n;
    @(negedge clk);
    enable_in = 1'b0;
    cpu_addr = 16'h0080;
    slv_mode = M_ACK;
    slv_wait = 3;
    bus0 = n_bus;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (n_bus !== bus0 || cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low_idle: cycles=%0d enable=%b required 0 0", n_bus - bus0, cpu_enable);
    end
    enable_in = 1'b1;
    n = 0;
    while (wb_cyc_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    enable_in = 1'b0;
    n = 0;
    while (wb_cyc_o === 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    $display("txn enable_gate adr=0080 cyc_len=%0d", cyc_len);
    n_checks++;
    if (cyc_len !== 4 || n_bus - bus0 !== 1) begin
      n_fail++;
      $display("FAIL enable_drop_mid_cycle: len=%0d cycles=%0d required 4 1", cyc_len, n_bus - bus0);
    end
    n_checks++;
    if (cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_gated: got %b required 0", cpu_enable);
    end
    enable_in = 1'b1;
    #1;
    n_checks++;
    if (cpu_enable !== 1'b1 || cpu_data_in !== ref_mem[8'h80]) begin
      n_fail++;
      $display("FAIL enable_resume: enable=%b data=%h required 1 %h", cpu_enable, cpu_data_in,
               ref_mem[8'h80]);
    end
    ref_valid = 1'b1; ref_addr = 16'h0080; ref_data = ref_mem[8'h80];
  endtask

  task automatic test_reset_mid_read();
    int n;
    @(negedge clk);
    enable_in = 1'b1;
    cpu_write_en = 1'b0;
    cpu_addr = 16'h0090;
    slv_mode = M_NONE;
    slv_wait = 0;
    n = 0;
    #1;
    while (wb_cyc_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (wb_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_start: cyc=%b required 1", wb_cyc_o);
    end
    #1 reset = 1'b1;
    #1;
    $display("txn reset_mid_read adr=0090 cyc=%b stb=%b", wb_cyc_o, wb_stb_o);
    n_checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: cyc=%b stb=%b enable=%b required 000", wb_cyc_o, wb_stb_o,
               cpu_enable);
    end
    enable_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_valid = 1'b0;
    cpu_access(1'b0, 16'h0090, 16'h0000, M_ACK, 0, "reread_after_reset");
  endtask

  task automatic test_random();
    int           r;
    int           mode;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] d;
    for (int i = 0; i < 40; i++) begin
      we = ($urandom_range(0, 9) < 3);
      a = 16'h00A0 + W'($urandom_range(0, 3));
      d = W'($urandom);
      r = $urandom_range(0, 9);
      mode = (r < 7) ? M_ACK : (r == 7) ? M_ERR : (r == 8) ? M_NONE : M_BOTH;
      cpu_access(we, a, d, mode, $urandom_range(0, 3), "random");
    end
  endtask

  // Instance B polls one address; every enabled cycle must follow a fresh read.
  task automatic test_refetch_poll();
    int           since;
    int           enables;
    logic         prev;
    logic [W-1:0] slave_data;
    logic [W-1:0] last_ack;
    since = 0;
    enables = 0;
    prev = 1'b0;
    slave_data = 16'h0001;
    last_ack = '0;
    @(negedge clk);
    b_cpu_addr = 16'h0030;
    b_enable_in = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (b_wb_cyc_o && !prev) since++;
      if (b_cpu_enable) begin
        enables++;
        $display("txn poll adr=%h data_in=%h reads_since=%0d", b_cpu_addr, b_cpu_data_in, since);
        n_checks++;
        if (since !== 1 || b_cpu_data_in !== last_ack) begin
          n_fail++;
          $display("FAIL poll_fresh: reads=%0d data=%h required 1 %h", since, b_cpu_data_in, last_ack);
        end
        since = 0;
      end
      b_wb_ack_i = b_wb_cyc_o && b_wb_stb_o;
      if (b_wb_ack_i) begin
        b_wb_dat_i = slave_data;
        last_ack = slave_data;
      end
      prev = b_wb_cyc_o;
      if (c == 18) slave_data = 16'h0002;
    end
    b_enable_in = 1'b0;
    b_wb_ack_i = 1'b0;
    n_checks++;
    if (enables < 10 || b_cpu_data_in !== 16'h0002) begin
      n_fail++;
      $display("FAIL poll_track: enables=%0d data=%h required >=10 0002", enables, b_cpu_data_in);
    end
  endtask

  initial begin
    logic [W-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = W'($urandom);
      slv_mem[i] = v;
      ref_mem[i] = v;
    end
    slv_mem[8'h10] = 16'hBEEF;
    ref_mem[8'h10] = 16'hBEEF;
    test_reset();
    test_read_ack();
    test_write_wait();
    test_timeout();
    test_err_ack();
    test_addr_change();
    test_enable_gate();
    test_reset_mid_read();
    test_random();
    test_refetch_poll();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
